// File: rtl/adder_slice_sequencer.sv
// adder_slice_sequencer
//   Multi-cycle WIDTH-bit adder built around one shared external 4-bit
//   ripple-carry slice. Two requesters are arbitrated round-robin. The accepted
//   operation is fed to the slice one nibble per cycle, LSB first, with the
//   carry chained through a register. The result is returned on a valid/ready
//   response port.
//   Optional feature macro: OVERFLOW_FLAG_EN adds rsp_ovf, the two's-complement
//   overflow of the completed addition.
module adder_slice_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic [3:0]       sl_a,
  output logic [3:0]       sl_b,
  output logic             sl_cin,
  input  logic [3:0]       sl_sum,
  input  logic             sl_cout,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_sum,
  output logic             rsp_cout,
  output logic             rsp_id
`ifdef OVERFLOW_FLAG_EN
  ,
  output logic             rsp_ovf
`endif
);

  localparam int NSL = WIDTH / 4;
  localparam int IW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSL - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // Operands held for the whole multi-cycle addition.
  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } op_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic          carry;
  logic          last_grant;
  op_t           op;

  logic          any_valid;
  logic          sel;       // requester picked this cycle (0/1)

  // Round-robin pick: a lone requester wins; under contention the one not
  // served last wins, so back-to-back contention strictly alternates.
  always_comb begin
    any_valid  = req0_valid | req1_valid;
    sel        = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    req0_ready = (state == IDLE) & any_valid & ~sel;
    req1_ready = (state == IDLE) & any_valid &  sel;
  end

  // Slice operands: current nibble while running, quiet zeros otherwise.
  always_comb begin
    sl_a   = 4'h0;
    sl_b   = 4'h0;
    sl_cin = 1'b0;
    if (state == RUN) begin
      sl_a   = op.a[4*idx +: 4];
      sl_b   = op.b[4*idx +: 4];
      sl_cin = carry;
    end
  end

  // Controller: accept, step the slice NSL times, hold the result until taken.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      carry      <= 1'b0;
      last_grant <= 1'b1;
      op         <= '0;
      rsp_valid  <= 1'b0;
      rsp_sum    <= '0;
      rsp_cout   <= 1'b0;
      rsp_id     <= 1'b0;
`ifdef OVERFLOW_FLAG_EN
      rsp_ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (req0_ready | req1_ready) begin
            op.a       <= req1_ready ? req1_a   : req0_a;
            op.b       <= req1_ready ? req1_b   : req0_b;
            carry      <= req1_ready ? req1_cin : req0_cin;
            rsp_id     <= req1_ready;
            last_grant <= req1_ready;
            idx        <= '0;
            state      <= RUN;
          end
        end
        RUN: begin
          rsp_sum[4*idx +: 4] <= sl_sum;
          carry               <= sl_cout;
          if (idx == LAST) begin
            idx       <= '0;
            rsp_cout  <= sl_cout;
`ifdef OVERFLOW_FLAG_EN
            // Carry into the sign bit differs from carry out of it.
            rsp_ovf   <= (sl_a[3] ^ sl_b[3] ^ sl_sum[3]) ^ sl_cout;
`endif
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
